atmr_seq_voter: RTL and testbench
=================================

Name: atmr_seq_voter

Overview:
- Registered, parametrised successor to the combinational per-output TMR voters used in the ATMR benchmark wrappers.
- Takes three replica output vectors (ori, mai, men) and produces a bitwise-majority vote one cycle later.
- Tracks per-replica consecutive disagreement; a persistently disagreeing replica is retired and the block degrades to duplex compare.
- Raises an alarm if the two survivors then disagree. Sits between the replica logic and the benchmark primary outputs.

Parameters:
WIDTH, 10, bits per replica vector / voted output
THRESH, 4, consecutive valid disagreeing cycles before a replica is retired (1..255)
EVT_W, 16, width of saturating mismatch-event counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  replica vectors valid this cycle
clear_i  in  1  return to NORMAL, clear counters and retirement
ori_i  in  WIDTH  replica 0 vector
mai_i  in  WIDTH  replica 1 vector
men_i  in  WIDTH  replica 2 vector
z_o  out  WIDTH  voted/selected output, registered
valid_o  out  1  z_o updated this cycle
mismatch_o  out  3  per-replica disagreement flag for the last valid cycle, bit k = replica k
state_o  out  2  0 NORMAL, 1 DEGRADED, 2 ALARM
failed_o  out  2  retired replica index 0..2; 3 = none
alarm_o  out  1  high while in ALARM
evt_cnt_o  out  EVT_W  saturating count of valid cycles with any mismatch

Behaviour:
- One clock, synchronous active-high reset on clk.
- Reset values: z_o=0, valid_o=0, mismatch_o=0, state_o=NORMAL, failed_o=3, alarm_o=0, evt_cnt_o=0, all internal run counters 0.
- Latency: 1 cycle. Inputs sampled on the valid_i edge appear on z_o/valid_o the next cycle. valid_o=valid_i delayed by 1 and is forced 0 in any cycle where clear_i was sampled.
- Priority: rst > clear_i > valid_i.
- clear_i: same effect as reset, except evt_cnt_o is also cleared and z_o holds its value. Inputs in the same cycle are ignored.
- NORMAL:
  - v = (ori&mai)|(ori&men)|(mai&men).
  - Replica k disagrees when its vector != v.
  - z_o <= v; mismatch_o[k] <= disagree_k.
  - run_k counts consecutive valid disagreeing cycles for replica k, cleared on a valid agreeing cycle, saturating at THRESH.
  - Cycles with valid_i=0 hold run_k, mismatch_o and z_o.
- NORMAL to DEGRADED: exactly one run_k reaches THRESH on this valid cycle. failed_o <= k and state <= DEGRADED, both visible next cycle together with that cycle's voted z_o.
- NORMAL to ALARM: two or more run_k reach THRESH on the same cycle. failed_o <= lowest such index.
- DEGRADED:
  - Survivors a<b, the two non-failed indices.
  - If vec_a == vec_b: z_o <= vec_a, mismatch_o <= 0.
  - Else: z_o holds its previous value, mismatch_o[a] and mismatch_o[b] <= 1, state <= ALARM.
  - The failed replica's input is ignored; its mismatch bit is 0.
- ALARM: alarm_o=1. z_o frozen, valid_o keeps pulsing with valid_i, mismatch_o frozen. Only clear_i or rst exits.
- evt_cnt_o increments on every valid cycle where any mismatch_o bit is set next, in every state except ALARM. It saturates at all-ones without wrap.
- THRESH=1 is legal: the first disagreement retires the replica immediately.
- A run_k counter stays held (not cleared) after its replica is retired.

Test Plan:
- Reset, then three identical vectors 0x155 with valid_i=1 -> next cycle z_o=0x155, valid_o=1, mismatch_o=000, state_o=0, failed_o=3, evt_cnt_o=0.
- ori=0x001, mai=men=0x000 for 3 valid cycles, then all 0x000 -> z_o=0x000 throughout, mismatch_o=001 for 3 cycles then 000, run cleared, state_o stays 0, evt_cnt_o=3.
- mai=0x3FF, ori=men=0x000 for 4 consecutive valid cycles, with valid_i=0 gaps between them -> after the 4th, state_o=1 and failed_o=1; gaps do not reset the run.
- From that DEGRADED state, ori=0x00F, men=0x00E -> state_o=2, alarm_o=1, z_o holds 0x000, mismatch_o=101. Then clear_i=1 -> state_o=0, failed_o=3, evt_cnt_o=0, valid_o=0.
- ori differs only in bit0 and men only in bit9 for 4 cycles (mai correct) -> both runs hit THRESH together -> state_o=2, failed_o=0.
- EVT_W=4 with 20 mismatching valid cycles and THRESH=255 -> evt_cnt_o saturates at 0xF. Asserting rst mid-run returns every output to its reset value on the next edge.

Source files
------------

// File: rtl/atmr_seq_voter.sv
// Registered triple-replica majority voter with replica retirement.
// Votes three replica vectors bitwise, tracks each replica's run of
// consecutive disagreements, retires a persistently wrong replica and
// falls back to duplex compare, then alarms if the two survivors differ.
//
// Handshake: valid_i qualifies ori_i/mai_i/men_i in the cycle it is high;
// there is no back-pressure. valid_o is valid_i delayed by one cycle and
// marks the cycle in which z_o/mismatch_o carry the result of that sample.
// A cycle with clear_i high never produces valid_o.
module atmr_seq_voter #(
  parameter int WIDTH  = 10,
  parameter int THRESH = 4,
  parameter int EVT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] ori_i,
  input  logic [WIDTH-1:0] mai_i,
  input  logic [WIDTH-1:0] men_i,
  output logic [WIDTH-1:0] z_o,
  output logic             valid_o,
  output logic [2:0]       mismatch_o,
  output logic [1:0]       state_o,
  output logic [1:0]       failed_o,
  output logic             alarm_o,
  output logic [EVT_W-1:0] evt_cnt_o
);

  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0] THR     = RUN_W'(THRESH);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
  localparam logic [1:0]       NONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_ALARM    = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [WIDTH-1:0]            z_q, z_d;
  logic                        valid_q, valid_d;
  logic [2:0]                  mismatch_q, mismatch_d;
  logic [1:0]                  failed_q, failed_d;
  logic [EVT_W-1:0]            evt_q, evt_d;
  logic [2:0][RUN_W-1:0]       run_q, run_d;

  logic [2:0][WIDTH-1:0]       vec;
  logic [WIDTH-1:0]            vote;
  logic [2:0]                  dis;
  logic [2:0]                  hit;
  logic [2:0][RUN_W-1:0]       run_inc;
  logic [1:0]                  surv_a, surv_b;

  // Majority vote, per-replica disagreement and run-length bookkeeping.
  always_comb begin
    vec[0] = ori_i;
    vec[1] = mai_i;
    vec[2] = men_i;
    vote   = (ori_i & mai_i) | (ori_i & men_i) | (mai_i & men_i);
    for (int k = 0; k < 3; k++) begin
      dis[k]     = (vec[k] != vote);
      run_inc[k] = (run_q[k] >= THR) ? run_q[k] : run_q[k] + RUN_ONE;
      hit[k]     = dis[k] && (run_inc[k] == THR);
    end
    // Survivor pair once a replica has been retired, lower index first.
    case (failed_q)
      2'd0:    begin surv_a = 2'd1; surv_b = 2'd2; end
      2'd1:    begin surv_a = 2'd0; surv_b = 2'd2; end
      default: begin surv_a = 2'd0; surv_b = 2'd1; end
    endcase
  end

  // Next-state logic for the voter FSM and all registered outputs.
  always_comb begin
    state_d    = state_q;
    z_d        = z_q;
    valid_d    = 1'b0;
    mismatch_d = mismatch_q;
    failed_d   = failed_q;
    evt_d      = evt_q;
    run_d      = run_q;
    if (clear_i) begin
      state_d    = ST_NORMAL;
      mismatch_d = '0;
      failed_d   = NONE;
      evt_d      = '0;
      run_d      = '0;
    end else if (valid_i) begin
      valid_d = 1'b1;
      case (state_q)
        ST_NORMAL: begin
          z_d        = vote;
          mismatch_d = dis;
          for (int k = 0; k < 3; k++) begin
            run_d[k] = dis[k] ? run_inc[k] : '0;
          end
          case (hit)
            3'b000: ;
            3'b001: begin state_d = ST_DEGRADED; failed_d = 2'd0; end
            3'b010: begin state_d = ST_DEGRADED; failed_d = 2'd1; end
            3'b100: begin state_d = ST_DEGRADED; failed_d = 2'd2; end
            default: begin
              state_d  = ST_ALARM;
              failed_d = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);
            end
          endcase
        end
        ST_DEGRADED: begin
          if (vec[surv_a] == vec[surv_b]) begin
            z_d        = vec[surv_a];
            mismatch_d = '0;
          end else begin
            mismatch_d         = '0;
            mismatch_d[surv_a] = 1'b1;
            mismatch_d[surv_b] = 1'b1;
            state_d            = ST_ALARM;
          end
        end
        default: ;
      endcase
      // Mismatch events are counted outside ALARM only, saturating.
      if ((state_q != ST_ALARM) && (|mismatch_d) && (evt_q != '1)) begin
        evt_d = evt_q + EVT_ONE;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      z_q        <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= '0;
      failed_q   <= NONE;
      evt_q      <= '0;
      run_q      <= '0;
    end else begin
      state_q    <= state_d;
      z_q        <= z_d;
      valid_q    <= valid_d;
      mismatch_q <= mismatch_d;
      failed_q   <= failed_d;
      evt_q      <= evt_d;
      run_q      <= run_d;
    end
  end

  assign z_o        = z_q;
  assign valid_o    = valid_q;
  assign mismatch_o = mismatch_q;
  assign state_o    = state_q;
  assign failed_o   = failed_q;
  assign alarm_o    = (state_q == ST_ALARM);
  assign evt_cnt_o  = evt_q;

endmodule

// File: tb/tb_atmr_seq_voter.sv
// Bench for atmr_seq_voter: two instances (default parameters, and
// THRESH=255/EVT_W=4) share one stimulus stream; a behavioural model per
// instance feeds expected-output queues that monitors drain.
module tb_atmr_seq_voter;

  logic       clk = 1'b0;
  logic       rst, valid_i, clear_i;
  logic [9:0] ori, mai, men;

  logic [9:0]  za, zb;
  logic        va, vb, ala, alb;
  logic [2:0]  misa, misb;
  logic [1:0]  sta, stb, fla, flb;
  logic [15:0] eva;
  logic [3:0]  evb;

  // Clock generation.
  always #5 clk = ~clk;

  atmr_seq_voter #(.WIDTH(10), .THRESH(4), .EVT_W(16)) dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_i), .clear_i(clear_i),
    .ori_i(ori), .mai_i(mai), .men_i(men),
    .z_o(za), .valid_o(va), .mismatch_o(misa), .state_o(sta),
    .failed_o(fla), .alarm_o(ala), .evt_cnt_o(eva)
  );

  atmr_seq_voter #(.WIDTH(10), .THRESH(255), .EVT_W(4)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid_i), .clear_i(clear_i),
    .ori_i(ori), .mai_i(mai), .men_i(men),
    .z_o(zb), .valid_o(vb), .mismatch_o(misb), .state_o(stb),
    .failed_o(flb), .alarm_o(alb), .evt_cnt_o(evb)
  );

  // Reference model state: mode 0 normal, 1 degraded, 2 alarm.
  typedef struct packed {
    logic [1:0]      mode;
    logic [1:0]      failed;
    logic [2:0][7:0] run;
    logic [9:0]      z;
    logic [2:0]      mis;
    logic [15:0]     evt;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;

  // Expected outputs, packed as {z, mismatch, state, failed, alarm, evt}.
  logic [33:0] vq_a[$], iq_a[$], vq_b[$], iq_b[$];
  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;

  function automatic logic [33:0] pack(mdl_t m);
    return {m.z, m.mis, m.mode, m.failed, (m.mode == 2'd2), m.evt};
  endfunction

  // One clock of the behavioural model, from the rules in plain arithmetic.
  function automatic mdl_t step(mdl_t m, logic r, logic c, logic v,
                                logic [9:0] o, logic [9:0] a, logic [9:0] e,
                                int thresh, int evt_max);
    mdl_t       n;
    logic [9:0] vec[3];
    logic [9:0] maj;
    logic [2:0] dis;
    int         cnt, hits, first, sa, sb, nr;
    n = m;
    if (r) begin
      n = '0;
      n.failed = 2'd3;
      return n;
    end
    if (c) begin
      n.mode = 2'd0; n.failed = 2'd3; n.run = '0; n.mis = '0; n.evt = '0;
      return n;
    end
    if (!v) return n;
    vec[0] = o; vec[1] = a; vec[2] = e;
    if (m.mode == 2'd0) begin
      for (int i = 0; i < 10; i++) begin
        cnt = int'(vec[0][i]) + int'(vec[1][i]) + int'(vec[2][i]);
        maj[i] = (cnt >= 2);
      end
      hits = 0; first = -1;
      for (int k = 0; k < 3; k++) begin
        dis[k] = (vec[k] != maj);
        if (dis[k]) begin
          nr = int'(m.run[k]) + 1;
          if (nr > thresh) nr = thresh;
        end else begin
          nr = 0;
        end
        n.run[k] = 8'(nr);
        if (dis[k] && nr == thresh) begin
          hits++;
          if (first < 0) first = k;
        end
      end
      n.z = maj; n.mis = dis;
      if (hits == 1) begin n.mode = 2'd1; n.failed = 2'(first); end
      else if (hits >= 2) begin n.mode = 2'd2; n.failed = 2'(first); end
    end else if (m.mode == 2'd1) begin
      sa = -1; sb = -1;
      for (int k = 0; k < 3; k++) begin
        if (k != int'(m.failed)) begin
          if (sa < 0) sa = k; else sb = k;
        end
      end
      if (vec[sa] == vec[sb]) begin
        n.z = vec[sa]; n.mis = '0;
      end else begin
        n.mis = 3'((1 << sa) | (1 << sb));
        n.mode = 2'd2;
      end
    end
    if (m.mode != 2'd2 && n.mis != 3'b000 && int'(m.evt) < evt_max) n.evt = m.evt + 16'd1;
    return n;
  endfunction

  task automatic cmp(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual z=%h mis=%b st=%0d fl=%0d al=%b evt=%0d required z=%h mis=%b st=%0d fl=%0d al=%b evt=%0d @%0t",
               name, got[33:24], got[23:21], got[20:19], got[18:17], got[16], got[15:0],
               exp[33:24], exp[23:21], exp[20:19], exp[18:17], exp[16], exp[15:0], $time);
    end
  endtask

  // Driver: apply one cycle of inputs, advance models, queue expectations.
  task automatic cyc(input logic r, input logic c, input logic v,
                     input logic [9:0] o, input logic [9:0] a, input logic [9:0] e);
    rst = r; clear_i = c; valid_i = v; ori = o; mai = a; men = e;
    ma = step(ma, r, c, v, o, a, e, 4, 65535);
    mb = step(mb, r, c, v, o, a, e, 255, 15);
    if (v && !r && !c) begin
      vq_a.push_back(pack(ma)); vq_b.push_back(pack(mb));
    end else begin
      iq_a.push_back(pack(ma)); iq_b.push_back(pack(mb));
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  // Monitor for instance A: valid outputs vs. idle/hold outputs.
  always @(negedge clk) begin
    if (started) begin
      if (va) begin
        if (vq_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_valid actual valid_o=1 required valid_o=0 @%0t", $time);
        end else cmp("a_valid_out", {za, misa, sta, fla, ala, eva}, vq_a.pop_front());
      end else begin
        if (iq_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_missing_valid actual valid_o=0 required valid_o=1 @%0t", $time);
        end else cmp("a_idle_out", {za, misa, sta, fla, ala, eva}, iq_a.pop_front());
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (started) begin
      if (vb) begin
        if (vq_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_valid actual valid_o=1 required valid_o=0 @%0t", $time);
        end else cmp("b_valid_out", {zb, misb, stb, flb, alb, 12'h000, evb}, vq_b.pop_front());
      end else begin
        if (iq_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_missing_valid actual valid_o=0 required valid_o=1 @%0t", $time);
        end else cmp("b_idle_out", {zb, misb, stb, flb, alb, 12'h000, evb}, iq_b.pop_front());
      end
    end
  end

  initial begin
    logic [9:0] base, vo, vm, ve;
    int         bad;
    // Reset.
    cyc(1, 0, 0, 10'h000, 10'h000, 10'h000);
    cyc(1, 0, 0, 10'h000, 10'h000, 10'h000);
    // Identical vectors, then an idle gap.
    cyc(0, 0, 1, 10'h155, 10'h155, 10'h155);
    cyc(0, 0, 0, 10'h155, 10'h155, 10'h155);
    // Short ori disagreement run that does not reach THRESH.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 10'h001, 10'h000, 10'h000);
    cyc(0, 0, 1, 10'h000, 10'h000, 10'h000);
    // mai wrong on four valid cycles separated by idle gaps.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 10'h000, 10'h3FF, 10'h000);
      cyc(0, 0, 0, 10'h000, 10'h000, 10'h000);
    end
    // Survivors disagree, alarm holds, then clear.
    cyc(0, 0, 1, 10'h00F, 10'h000, 10'h00E);
    cyc(0, 0, 1, 10'h2AA, 10'h155, 10'h0F0);
    cyc(0, 0, 0, 10'h000, 10'h000, 10'h000);
    cyc(0, 1, 1, 10'h3FF, 10'h3FF, 10'h3FF);
    // Two replicas reach THRESH together.
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10'h001, 10'h000, 10'h200);
    cyc(0, 0, 1, 10'h000, 10'h000, 10'h000);
    cyc(0, 1, 0, 10'h000, 10'h000, 10'h000);
    // Long mismatch run: evt saturation on the 4-bit counter, reset mid-run.
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 10'h3FF, 10'h000, 10'h000);
    cyc(0, 0, 1, 10'h3FF, 10'h000, 10'h000);
    cyc(1, 0, 1, 10'h3FF, 10'h000, 10'h000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 10'h3FF, 10'h000, 10'h000);
    cyc(0, 1, 0, 10'h000, 10'h000, 10'h000);
    // Randomised traffic with a sometimes-persistent faulty replica.
    bad = 3;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) bad = $urandom_range(0, 3);
      base = 10'($urandom);
      vo = base; vm = base; ve = base;
      if ($urandom_range(0, 15) == 0) vo = vo ^ (10'd1 << $urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) vm = vm ^ (10'd1 << $urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) ve = ve ^ (10'd1 << $urandom_range(0, 9));
      if (bad < 3 && $urandom_range(0, 3) != 0) begin
        if (bad == 0) vo = base ^ (10'd1 << $urandom_range(0, 9));
        else if (bad == 1) vm = base ^ (10'd1 << $urandom_range(0, 9));
        else ve = base ^ (10'd1 << $urandom_range(0, 9));
      end
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0), vo, vm, ve);
    end
    cyc(0, 0, 0, 10'h000, 10'h000, 10'h000);
    #1;
    // Every queued expectation must have been consumed.
    checks++;
    if (vq_a.size() + iq_a.size() + vq_b.size() + iq_b.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual pending=%0d required pending=0",
               vq_a.size() + iq_a.size() + vq_b.size() + iq_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
